// File: rtl/ctrl_8085_pkg.sv
// Shared encodings for the 8085-style sequencer: opcodes, FSM states, ALU ops,
// accumulator sources and the opcode-decode record.
package ctrl_8085_pkg;

  localparam logic [3:0] OP_NOP = 4'h0, OP_MOV_AR = 4'h1, OP_MOV_RA = 4'h2, OP_ADD = 4'h3,
                         OP_SUB = 4'h4, OP_ANA = 4'h5, OP_ORA = 4'h6, OP_XRA = 4'h7,
                         OP_MVI = 4'h8, OP_ADI = 4'h9, OP_JMP = 4'hA, OP_JZ = 4'hB,
                         OP_JC = 4'hC, OP_CMP = 4'hD, OP_SUI = 4'hE, OP_HLT = 4'hF;

  typedef enum logic [2:0] {
    S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2,
    S_WB = 3'd3, S_BRANCH = 3'd4, S_HALT = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0, ALU_SUB = 3'd1, ALU_AND = 3'd2,
    ALU_OR = 3'd3, ALU_XOR = 3'd4, ALU_PASS_B = 3'd5
  } alu_op_t;

  localparam logic [1:0] ACC_ALU = 2'd0, ACC_REG = 2'd1, ACC_IMM = 2'd2;

  // CL_EXEC covers every opcode that walks EXEC->WB except MOV r,A (CL_STORE).
  typedef enum logic [2:0] {
    CL_NOP, CL_EXEC, CL_STORE, CL_JMP, CL_JZ, CL_JC, CL_HLT
  } op_class_t;

  typedef struct packed {
    op_class_t  cls;
    alu_op_t    alu_op;
    logic       alu_b_sel;
    logic [1:0] acc_src;
    logic       writes_acc;
    logic       writes_flags;
  } dec_t;

endpackage

// File: rtl/opdec_8085.sv
// Combinational opcode decode; the sequencer FSM only consumes this record.
module opdec_8085
  import ctrl_8085_pkg::*;
(
  input  logic [3:0] opcode,
  output dec_t       dec
);

  always_comb begin
    dec.cls          = CL_EXEC;
    dec.alu_op       = ALU_ADD;
    dec.alu_b_sel    = 1'b0;
    dec.acc_src      = ACC_ALU;
    dec.writes_acc   = 1'b0;
    dec.writes_flags = 1'b0;
    case (opcode)
      OP_NOP:    dec.cls = CL_NOP;
      OP_JMP:    dec.cls = CL_JMP;
      OP_JZ:     dec.cls = CL_JZ;
      OP_JC:     dec.cls = CL_JC;
      OP_HLT:    dec.cls = CL_HLT;
      OP_MOV_AR: begin dec.alu_op = ALU_PASS_B; dec.acc_src = ACC_REG; dec.writes_acc = 1'b1; end
      OP_MOV_RA: begin dec.cls = CL_STORE; dec.alu_op = ALU_PASS_B; end
      OP_MVI: begin
        dec.alu_op = ALU_PASS_B; dec.alu_b_sel = 1'b1;
        dec.acc_src = ACC_IMM; dec.writes_acc = 1'b1;
      end
      OP_ADD:  begin dec.alu_op = ALU_ADD; dec.writes_acc = 1'b1; dec.writes_flags = 1'b1; end
      OP_SUB:  begin dec.alu_op = ALU_SUB; dec.writes_acc = 1'b1; dec.writes_flags = 1'b1; end
      OP_ANA:  begin dec.alu_op = ALU_AND; dec.writes_acc = 1'b1; dec.writes_flags = 1'b1; end
      OP_ORA:  begin dec.alu_op = ALU_OR;  dec.writes_acc = 1'b1; dec.writes_flags = 1'b1; end
      OP_XRA:  begin dec.alu_op = ALU_XOR; dec.writes_acc = 1'b1; dec.writes_flags = 1'b1; end
      OP_ADI: begin
        dec.alu_op = ALU_ADD; dec.alu_b_sel = 1'b1;
        dec.writes_acc = 1'b1; dec.writes_flags = 1'b1;
      end
      OP_SUI: begin
        dec.alu_op = ALU_SUB; dec.alu_b_sel = 1'b1;
        dec.writes_acc = 1'b1; dec.writes_flags = 1'b1;
      end
      OP_CMP:  begin dec.alu_op = ALU_SUB; dec.writes_flags = 1'b1; end
      default: dec.cls = CL_NOP;
    endcase
  end

endmodule

// File: rtl/microseq_8085.sv
// Instruction-cycle FSM for the accumulator datapath: Moore-decoded enables and
// selects from the state register and IR opcode; only BRANCH looks at z/cy.
module microseq_8085
  import ctrl_8085_pkg::*;
#(
  parameter int IMM_W              = 8,
  parameter bit HALT_ON_RESET_ONLY = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] ir,
  input  logic        z,
  input  logic        cy,
  output logic        pc_write,
  output logic        pc_src,
  output logic        ir_write,
  output logic        acc_write,
  output logic [1:0]  acc_src,
  output logic        reg_write,
  output logic [2:0]  alu_op,
  output logic        alu_b_sel,
  output logic        flag_write,
  output logic [2:0]  state,
  output logic        halted,
  output logic        instr_done
);

  state_t st_q, st_d;
  dec_t   dec;

  // Register index and immediate feed the datapath muxes directly, not the FSM.
  logic [IMM_W-1:0] unused_imm;
  logic [3:0]       unused_rsel;
  assign unused_imm  = ir[IMM_W-1:0];
  assign unused_rsel = ir[11:8];

  opdec_8085 u_dec (
    .opcode (ir[15:12]),
    .dec    (dec)
  );

  always_ff @(posedge clk) begin
    if (reset) st_q <= S_FETCH;
    else       st_q <= st_d;
  end

  always_comb begin
    st_d       = S_FETCH;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    ir_write   = 1'b0;
    acc_write  = 1'b0;
    acc_src    = ACC_ALU;
    reg_write  = 1'b0;
    alu_op     = ALU_ADD;
    alu_b_sel  = 1'b0;
    flag_write = 1'b0;
    halted     = 1'b0;
    instr_done = 1'b0;
    case (st_q)
      S_FETCH: begin
        ir_write = 1'b1;
        pc_write = 1'b1;
        st_d     = S_DECODE;
      end
      S_DECODE: begin
        case (dec.cls)
          CL_NOP:               begin instr_done = 1'b1; st_d = S_FETCH; end
          CL_JMP, CL_JZ, CL_JC: st_d = S_BRANCH;
          CL_HLT:               st_d = S_HALT;
          default:              st_d = S_EXEC;
        endcase
      end
      S_EXEC: begin
        alu_op    = dec.alu_op;
        alu_b_sel = dec.alu_b_sel;
        st_d      = S_WB;
      end
      S_WB: begin
        alu_op     = dec.alu_op;
        alu_b_sel  = dec.alu_b_sel;
        acc_write  = dec.writes_acc;
        acc_src    = dec.acc_src;
        flag_write = dec.writes_flags;
        reg_write  = (dec.cls == CL_STORE);
        instr_done = 1'b1;
        st_d       = S_FETCH;
      end
      S_BRANCH: begin
        pc_src     = 1'b1;
        pc_write   = (dec.cls == CL_JMP) | ((dec.cls == CL_JZ) & z) | ((dec.cls == CL_JC) & cy);
        instr_done = 1'b1;
        st_d       = S_FETCH;
      end
      S_HALT: begin
        halted = 1'b1;
        // With the parameter cleared, HALT is a single-cycle pause instead of a stop.
        if (HALT_ON_RESET_ONLY) st_d = S_HALT;
        else                    st_d = S_FETCH;
      end
      default: st_d = S_FETCH;
    endcase
    if (reset) begin
      pc_write   = 1'b0;
      pc_src     = 1'b0;
      ir_write   = 1'b0;
      acc_write  = 1'b0;
      acc_src    = ACC_ALU;
      reg_write  = 1'b0;
      alu_op     = ALU_ADD;
      alu_b_sel  = 1'b0;
      flag_write = 1'b0;
      halted     = 1'b0;
      instr_done = 1'b0;
    end
  end

  assign state = reset ? 3'd0 : st_q;

endmodule
